imem_fetch_ctrl: RTL and testbench

//  Fetch sequencer for the combinational 1 KiB instruction ROM: owns the fetch PC, drives the
//  ROM byte address each cycle and captures {pc, instruction} into a 2-entry skid FIFO.
//  The FIFO drains to the decode stage over a valid/ready handshake.

---
 rtl/imem_pkg.sv | 16 +
 rtl/fetch_fifo2.sv | 48 ++++
 rtl/imem_fetch_ctrl.sv | 78 +++++++
 tb/tb_imem_fetch_ctrl.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared types for the instruction fetch path: ROM size, FIFO entry layout and the fetch FSM states.
package imem_pkg;
   localparam int INSTR_MEM_SIZE = 1024;
   localparam int FETCH_ADDR_W   = 64;
   localparam int FETCH_INSTR_W  = 32;

   typedef struct packed {
      logic [FETCH_ADDR_W-1:0]  pc;
      logic [FETCH_INSTR_W-1:0] instr;
   } fetch_entry_t;

   typedef enum logic {
      RUN   = 1'b0,
      FAULT = 1'b1
   } fetch_state_e;
endpackage

// File: rtl/fetch_fifo2.sv
// Two-entry skid FIFO of fetch entries; head is registered, one cycle push-to-head latency.
// Flush wins over push/pop; the caller never pushes when full without a simultaneous pop.
module fetch_fifo2
   import imem_pkg::*;
(
   input  logic         clk,
   input  logic         reset_n,
   input  logic         push,
   input  fetch_entry_t push_entry,
   input  logic         pop,
   input  logic         flush,
   output logic [1:0]   count,
   output fetch_entry_t head
);
   fetch_entry_t second;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count  <= 2'd0;
         head   <= '0;
         second <= '0;
      end else if (flush) begin
         count <= 2'd0;
      end else begin
         case ({push, pop})
            2'b10: begin
               if (count == 2'd0) head <= push_entry;
               else               second <= push_entry;
               count <= count + 2'd1;
            end
            2'b01: begin
               head  <= second;
               count <= count - 2'd1;
            end
            2'b11: begin
               // Occupancy is unchanged; the new entry lands behind whatever remains.
               if (count == 2'd1) begin
                  head <= push_entry;
               end else begin
                  head   <= second;
                  second <= push_entry;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: rtl/imem_fetch_ctrl.sv
// Fetch sequencer: owns the fetch PC, reads the ROM and queues {pc, instr} toward decode.
// First output 1 cycle after reset/redirect; PC freezes while the FIFO is full and decode stalls.
module imem_fetch_ctrl
   import imem_pkg::*;
#(
   parameter int                ADDR_W    = FETCH_ADDR_W,
   parameter int                INSTR_W   = FETCH_INSTR_W,
   parameter int                MEM_BYTES = INSTR_MEM_SIZE,
   parameter logic [ADDR_W-1:0] RESET_PC  = '0,
   parameter int                DEPTH     = 2
)(
   input  logic               clk,
   input  logic               reset_n,
   output logic [ADDR_W-1:0]  imem_address,
   input  logic [INSTR_W-1:0] imem_instr,
   input  logic               redirect_valid,
   input  logic [ADDR_W-1:0]  redirect_pc,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [INSTR_W-1:0] out_instr,
   output logic [ADDR_W-1:0]  out_pc,
   output logic               fetch_fault
);
   localparam logic [1:0]    FULL_COUNT = 2'(DEPTH);
   localparam logic [ADDR_W:0] LIMIT    = (ADDR_W+1)'(MEM_BYTES);

   fetch_state_e      state;
   logic [ADDR_W-1:0] fetch_pc;
   logic [ADDR_W:0]   last_byte;
   logic [1:0]        count;
   logic              bad;
   logic              push;
   logic              pop;
   fetch_entry_t      new_entry;
   fetch_entry_t      head;

   assign imem_address = fetch_pc;
   assign out_valid    = (count != 2'd0);
   assign pop          = out_valid & out_ready;

   // One extra bit so a PC near the top of the address space cannot wrap past the check.
   assign last_byte = {1'b0, fetch_pc} + (ADDR_W+1)'(3);
   assign bad       = (fetch_pc[1:0] != 2'b00) | (last_byte >= LIMIT);
   assign push      = (state == RUN) & ~bad & ((count < FULL_COUNT) | pop) & ~redirect_valid;
   assign new_entry = '{pc: fetch_pc, instr: imem_instr};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         fetch_pc    <= RESET_PC;
         state       <= RUN;
         fetch_fault <= 1'b0;
      end else if (redirect_valid) begin
         fetch_pc    <= redirect_pc;
         state       <= RUN;
         fetch_fault <= 1'b0;
      end else begin
         if (push) fetch_pc <= fetch_pc + ADDR_W'(4);
         if (state == RUN && bad) begin
            state       <= FAULT;
            fetch_fault <= 1'b1;
         end
      end
   end

   fetch_fifo2 u_fifo (
      .clk        (clk),
      .reset_n    (reset_n),
      .push       (push),
      .push_entry (new_entry),
      .pop        (pop),
      .flush      (redirect_valid),
      .count      (count),
      .head       (head)
   );

   assign out_instr = head.instr;
   assign out_pc    = head.pc;
endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Bench for imem_fetch_ctrl: ROM model, per-cycle vector table and an in-order scoreboard on accepted outputs.
`timescale 1ns/1ps
module tb_imem_fetch_ctrl;
   typedef struct {
      logic        rv;
      logic [63:0] rpc;
      logic        rdy;
      logic        vld;
      logic [63:0] pc;
      logic [63:0] addr;
      logic        flt;
   } vec_t;

   logic        clk;
   logic        reset_n;
   logic [63:0] imem_address;
   logic [31:0] imem_instr;
   logic        redirect_valid;
   logic [63:0] redirect_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [63:0] out_pc;
   logic        fetch_fault;

   logic [31:0] mem [256];
   logic [63:0] sb [$];
   int          n_cmp = 0;
   int          n_bad = 0;
   vec_t        tbl [17];

   imem_fetch_ctrl dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .imem_address   (imem_address),
      .imem_instr     (imem_instr),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_instr      (out_instr),
      .out_pc         (out_pc),
      .fetch_fault    (fetch_fault)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always_comb begin
      imem_instr = 32'hDEAD_BEEF;
      if (imem_address < 64'd1024) imem_instr = mem[imem_address[9:2]];
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic rv, input logic [63:0] rpc, input logic rdy,
                               input logic vld, input logic [63:0] pc, input logic [63:0] addr,
                               input logic flt);
      vec_t v;
      v.rv = rv; v.rpc = rpc; v.rdy = rdy; v.vld = vld; v.pc = pc; v.addr = addr; v.flt = flt;
      return v;
   endfunction

   // Drive one cycle of inputs, check the registered outputs mid-cycle, advance to the next cycle.
   task automatic apply(input vec_t v, input string tag);
      redirect_valid = v.rv;
      redirect_pc    = v.rpc;
      out_ready      = v.rdy;
      if (v.rdy && v.vld && !v.rv) sb.push_back(v.pc);
      #3;
      check({tag, "_vld"},   64'(out_valid),   64'(v.vld));
      check({tag, "_addr"},  imem_address,     v.addr);
      check({tag, "_fault"}, 64'(fetch_fault), 64'(v.flt));
      if (v.vld) check({tag, "_pc"}, out_pc, v.pc);
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin : monitor
      logic [63:0] e;
      if (reset_n && out_valid && out_ready && !redirect_valid) begin
         if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL sb_unexpected: got pc %h, expected no transfer", out_pc);
         end else begin
            e = sb.pop_front();
            check("sb_pc", out_pc, e);
            check("sb_instr", 64'(out_instr), 64'(mem[e[9:2]]));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      // Streaming, stall with full FIFO, then redirect while full.
      tbl[0]  = mk(0, 64'h0,  1, 0, 64'h0,  64'h0,  0);
      tbl[1]  = mk(0, 64'h0,  1, 1, 64'h0,  64'h4,  0);
      tbl[2]  = mk(0, 64'h0,  1, 1, 64'h4,  64'h8,  0);
      tbl[3]  = mk(0, 64'h0,  1, 1, 64'h8,  64'hC,  0);
      tbl[4]  = mk(0, 64'h0,  1, 1, 64'hC,  64'h10, 0);
      tbl[5]  = mk(1, 64'h0,  1, 1, 64'h10, 64'h14, 0);
      tbl[6]  = mk(0, 64'h0,  0, 0, 64'h0,  64'h0,  0);
      tbl[7]  = mk(0, 64'h0,  0, 1, 64'h0,  64'h4,  0);
      tbl[8]  = mk(0, 64'h0,  0, 1, 64'h0,  64'h8,  0);
      tbl[9]  = mk(0, 64'h0,  0, 1, 64'h0,  64'h8,  0);
      tbl[10] = mk(0, 64'h0,  0, 1, 64'h0,  64'h8,  0);
      tbl[11] = mk(0, 64'h0,  1, 1, 64'h0,  64'h8,  0);
      tbl[12] = mk(0, 64'h0,  1, 1, 64'h4,  64'hC,  0);
      tbl[13] = mk(0, 64'h0,  1, 1, 64'h8,  64'h10, 0);
      tbl[14] = mk(1, 64'h40, 1, 1, 64'hC,  64'h14, 0);
      tbl[15] = mk(0, 64'h0,  1, 0, 64'h0,  64'h40, 0);
      tbl[16] = mk(0, 64'h0,  1, 1, 64'h40, 64'h44, 0);

      for (int i = 0; i < 256; i++) mem[i] = $urandom;
      reset_n        = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      out_ready      = 1'b0;
      #1 reset_n = 1'b0;
      #1;
      check("rst_vld",   64'(out_valid),   64'd0);
      check("rst_pc",    out_pc,           64'd0);
      check("rst_instr", 64'(out_instr),   64'd0);
      check("rst_fault", 64'(fetch_fault), 64'd0);
      check("rst_addr",  imem_address,     64'd0);
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;

      for (int i = 0; i < 17; i++) apply(tbl[i], $sformatf("t%0d", i));

      // Run off the end of the ROM into FAULT, then recover by redirect.
      apply(mk(1, 64'h3F0, 1, 1, 64'h44,  64'h48,  0), "end_redir");
      apply(mk(0, 64'h0,   1, 0, 64'h0,   64'h3F0, 0), "end_b");
      apply(mk(0, 64'h0,   1, 1, 64'h3F0, 64'h3F4, 0), "end_c");
      apply(mk(0, 64'h0,   1, 1, 64'h3F4, 64'h3F8, 0), "end_d");
      apply(mk(0, 64'h0,   1, 1, 64'h3F8, 64'h3FC, 0), "end_e");
      apply(mk(0, 64'h0,   1, 1, 64'h3FC, 64'h400, 0), "end_last");
      apply(mk(0, 64'h0,   1, 0, 64'h0,   64'h400, 1), "end_fault");
      apply(mk(0, 64'h0,   1, 0, 64'h0,   64'h400, 1), "end_sticky");
      apply(mk(1, 64'h10,  1, 0, 64'h0,   64'h400, 1), "rec_redir");
      apply(mk(0, 64'h0,   1, 0, 64'h0,   64'h10,  0), "rec_clear");
      apply(mk(0, 64'h0,   1, 1, 64'h10,  64'h14,  0), "rec_first");

      // Misaligned redirect target: fault two cycles after the redirect, nothing queued.
      apply(mk(1, 64'h6,   1, 1, 64'h14,  64'h18,  0), "mis_redir");
      apply(mk(0, 64'h0,   1, 0, 64'h0,   64'h6,   0), "mis_bad");
      apply(mk(0, 64'h0,   1, 0, 64'h0,   64'h6,   1), "mis_fault");
      apply(mk(0, 64'h0,   1, 0, 64'h0,   64'h6,   1), "mis_hold");

      // Reset asserted mid-cycle with a full FIFO.
      apply(mk(1, 64'h80,  0, 0, 64'h0,   64'h6,   1), "mr_redir");
      apply(mk(0, 64'h0,   0, 0, 64'h0,   64'h80,  0), "mr_a");
      apply(mk(0, 64'h0,   0, 1, 64'h80,  64'h84,  0), "mr_b");
      apply(mk(0, 64'h0,   0, 1, 64'h80,  64'h88,  0), "mr_full");
      #2 reset_n = 1'b0;
      #1;
      check("mr_vld",   64'(out_valid),   64'd0);
      check("mr_pc",    out_pc,           64'd0);
      check("mr_instr", 64'(out_instr),   64'd0);
      check("mr_fault", 64'(fetch_fault), 64'd0);
      check("mr_addr",  imem_address,     64'd0);
      sb.delete();
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      apply(mk(0, 64'h0, 1, 0, 64'h0, 64'h0, 0), "post_a");
      apply(mk(0, 64'h0, 1, 1, 64'h0, 64'h4, 0), "post_b");

      check("sb_drained", 64'(sb.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
